// File: rtl/adc_seq_pkg.sv
// Shared encodings and defaults for the ADC conversion sequencer
// and its SPI/RAM wrappers.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CNV     = 3'd1,
    S_BUSY    = 3'd2,
    S_SPI_DLY = 3'd3,
    S_SPI     = 3'd4,
    S_DONE    = 3'd5
  } seq_state_t;

  localparam int DEF_CH_NUM       = 2;
  localparam int DEF_CYCLE_CLKS   = 200;
  localparam int DEF_CNV_CLKS     = 4;
  localparam int DEF_SPI_DLY_CLKS = 9;
  localparam int DEF_BUSY_TO_CLKS = 150;
  localparam int DEF_RAM_DEPTH    = 1024;
  localparam int DEF_ADDR_W       = 15;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/adc_valid_collector.sv
// Sticky per-channel data-valid mask; all-set looks through
// the current strobes so the write can follow the last one.
module adc_valid_collector
  import adc_seq_pkg::*;
#(
  parameter int CH_NUM = DEF_CH_NUM
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [CH_NUM-1:0] i_set,
  output logic              o_all
);

  logic [CH_NUM-1:0] r_mask;
  logic [CH_NUM-1:0] w_next;

  assign w_next = r_mask | (i_en ? i_set : '0);
  assign o_all  = &w_next;

  // mask accumulates strobes; repeats are harmless ORs
  always_ff @(posedge i_clk) begin
    if (!i_rst)
      r_mask <= '0;
    else if (i_clr)
      r_mask <= '0;
    else
      r_mask <= w_next;
  end

endmodule

// File: rtl/adc_cnv_seq.sv
// Conversion sequencer: periodic CNV, BUSY tracking, SPI kick,
// ping-pong RAM row writes, timeout and overrun handling.
module adc_cnv_seq
  import adc_seq_pkg::*;
#(
  parameter int CH_NUM       = DEF_CH_NUM,
  parameter int CYCLE_CLKS   = DEF_CYCLE_CLKS,
  parameter int CNV_CLKS     = DEF_CNV_CLKS,
  parameter int SPI_DLY_CLKS = DEF_SPI_DLY_CLKS,
  parameter int BUSY_TO_CLKS = DEF_BUSY_TO_CLKS,
  parameter int RAM_DEPTH    = DEF_RAM_DEPTH,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [CH_NUM-1:0] i_adc_busy,
  input  logic [CH_NUM-1:0] i_spi_data_valid,
  output logic              o_adc_cnv,
  output logic              o_spi_start,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [1:0]        o_half_done,
  output logic              o_busy_to_err,
  output logic              o_overrun_err,
  output logic [15:0]       o_err_cnt,
  output logic [2:0]        o_state
);

  localparam int CW = $clog2(CYCLE_CLKS);
  localparam int DW = $clog2(SPI_DLY_CLKS + 1);

  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLE_CLKS - 1);
  localparam logic [CW-1:0] CNV_LIM  = CW'(CNV_CLKS);
  localparam logic [CW-1:0] TO_LIM   = CW'(BUSY_TO_CLKS);
  localparam logic [DW-1:0] DLY_LAST = DW'(SPI_DLY_CLKS - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] A_HALF = ADDR_W'(RAM_DEPTH / 2 - 1);

  seq_state_t        r_state;
  seq_state_t        w_nxt;
  logic [CW-1:0]     r_cyc;
  logic [DW-1:0]     r_dly;
  logic [ADDR_W-1:0] r_addr;
  logic              r_to_err;
  logic              r_ov_err;
  logic [15:0]       r_err_cnt;
  logic              w_start;
  logic              w_to;
  logic              w_ov;
  logic              w_all;

  assign w_start = (r_cyc == '0);

  adc_valid_collector #(
    .CH_NUM (CH_NUM)
  ) u_vcol (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (r_state != S_SPI),
    .i_en  (r_state == S_SPI),
    .i_set (i_spi_data_valid),
    .o_all (w_all)
  );

  // next state; an unfinished cycle at cycle start is aborted
  always_comb begin
    w_nxt = r_state;
    w_to  = 1'b0;
    w_ov  = 1'b0;
    if (w_start && r_state != S_IDLE && r_state != S_DONE) begin
      w_ov  = 1'b1;
      w_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (w_start && i_en) w_nxt = S_CNV;
        S_CNV:
          if (r_cyc == TO_LIM) begin
            w_to  = 1'b1;
            w_nxt = S_IDLE;
          end else if (&i_adc_busy) begin
            w_nxt = S_BUSY;
          end
        S_BUSY:
          if (r_cyc == TO_LIM) begin
            w_to  = 1'b1;
            w_nxt = S_IDLE;
          end else if (~|i_adc_busy) begin
            w_nxt = S_SPI_DLY;
          end
        S_SPI_DLY:
          if (r_dly == DLY_LAST) w_nxt = S_SPI;
        S_SPI:
          if (w_all) w_nxt = S_DONE;
        S_DONE:
          w_nxt = (w_start && i_en) ? S_CNV : S_IDLE;
        default:
          w_nxt = S_IDLE;
      endcase
    end
  end

  // state, counters, address and sticky error bookkeeping
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_cyc     <= '0;
      r_dly     <= '0;
      r_addr    <= '0;
      r_to_err  <= 1'b0;
      r_ov_err  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      r_cyc   <= (r_cyc == CYC_LAST) ? '0 : r_cyc + 1'b1;
      if (r_state == S_SPI_DLY && w_nxt == S_SPI_DLY)
        r_dly <= r_dly + 1'b1;
      else
        r_dly <= '0;
      if (r_state == S_DONE)
        r_addr <= (r_addr == A_LAST) ? '0 : r_addr + 1'b1;
      if (w_to)
        r_to_err <= 1'b1;
      if (w_ov)
        r_ov_err <= 1'b1;
      if (w_to || w_ov)
        r_err_cnt <= sat_inc16(r_err_cnt);
    end
  end

  assign o_adc_cnv     = (r_state != S_IDLE) && (r_cyc < CNV_LIM);
  assign o_spi_start   = (r_state == S_SPI_DLY) && (r_dly == DLY_LAST);
  assign o_ram_we      = (r_state == S_DONE);
  assign o_ram_addr    = r_addr;
  assign o_half_done   = {o_ram_we && (r_addr == A_LAST),
                          o_ram_we && (r_addr == A_HALF)};
  assign o_busy_to_err = r_to_err;
  assign o_overrun_err = r_ov_err;
  assign o_err_cnt     = r_err_cnt;
  assign o_state       = r_state;

endmodule
